pic_intr_ctrl: RTL and testbench

PIC_INTR_CTRL -- requirements
Module: pic_intr_ctrl

---
 rtl/pic_intr_ctrl.sv | 159 +++++++++++++++
 tb/tb_pic_intr_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pic_intr_ctrl.sv
// 8-level interrupt controller: fully nested priority, INTA handshake, EOI/AEOI.
// Optional ROTATE_EN macro enables rotating priority on non-specific EOI and AEOI.
module pic_intr_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] vec_base,
    input  logic       aeoi,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] irr_clr,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

    state_t     state_q, state_d;
    logic [7:0] isr_q, isr_d, isr_e;
    logic [7:0] irr_clr_q, irr_clr_d;
    logic [7:0] vector_q, vector_d;
    logic       int_q, int_d;
    logic       vv_q, vv_d;
    logic       spur_q, spur_d;
    logic [2:0] level_q, level_d;
    logic [2:0] ptr_cur, ptr_e, base_e, top;
    logic [2:0] c_rank, i_rank, cand;
    logic [7:0] req;
    logic       elig;

    // Rank 0 is the highest priority; base is the level holding rank 0.
    function automatic logic [2:0] top_rank(input logic [7:0] v,
                                            input logic [2:0] base);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[base + 3'(i)]) r = 3'(i);
        end
        return r;
    endfunction

`ifdef ROTATE_EN
    logic [2:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_e;
        if (state_q == ACK1 && inta && aeoi && !spur_q) ptr_d = level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 3'd7;
        else       ptr_q <= ptr_d;
    end
`endif

    always_comb begin
`ifdef ROTATE_EN
        ptr_cur = ptr_q;
`else
        ptr_cur = 3'd7;
`endif
        top = ptr_cur + 3'd1 + top_rank(isr_q, ptr_cur + 3'd1);

        // EOI is applied before eligibility is evaluated in the same cycle.
        isr_e = isr_q;
        if (eoi) begin
            if (eoi_specific)  isr_e[eoi_level] = 1'b0;
            else if (|isr_q)   isr_e[top] = 1'b0;
        end
`ifdef ROTATE_EN
        ptr_e = (eoi && !eoi_specific && |isr_q) ? top : ptr_q;
`else
        ptr_e = 3'd7;
`endif
        base_e = ptr_e + 3'd1;
        req    = irr & ~imr;
        c_rank = top_rank(req, base_e);
        i_rank = top_rank(isr_e, base_e);
        cand   = base_e + c_rank;
        elig   = (|req) && ((isr_e == 8'd0) || (c_rank < i_rank));

        state_d   = state_q;
        isr_d     = isr_e;
        int_d     = 1'b0;
        irr_clr_d = 8'd0;
        vector_d  = vector_q;
        vv_d      = 1'b0;
        level_d   = level_q;
        spur_d    = spur_q;

        unique case (state_q)
            IDLE: begin
                if (elig) begin
                    state_d = PEND;
                    int_d   = 1'b1;
                end
            end
            PEND: begin
                int_d = elig;
                if (inta) begin
                    int_d   = 1'b0;
                    state_d = ACK1;
                    if (elig) begin
                        level_d     = cand;
                        isr_d[cand] = 1'b1;
                        irr_clr_d   = 8'd1 << cand;
                        spur_d      = 1'b0;
                    end else begin
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta) begin
                    vector_d = {vec_base, level_q};
                    vv_d     = 1'b1;
                    state_d  = IDLE;
                    if (aeoi && !spur_q) isr_d[level_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            isr_q     <= 8'd0;
            irr_clr_q <= 8'd0;
            vector_q  <= 8'd0;
            int_q     <= 1'b0;
            vv_q      <= 1'b0;
            spur_q    <= 1'b0;
            level_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
            vector_q  <= vector_d;
            int_q     <= int_d;
            vv_q      <= vv_d;
            spur_q    <= spur_d;
            level_q   <= level_d;
        end
    end

    assign int_out      = int_q;
    assign isr          = isr_q;
    assign irr_clr      = irr_clr_q;
    assign vector       = vector_q;
    assign vector_valid = vv_q;

endmodule

// File: tb/tb_pic_intr_ctrl.sv
// Table-driven scoreboard bench for pic_intr_ctrl.
module tb_pic_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr, imr;
    logic [4:0] vec_base;
    logic       aeoi, inta, eoi, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out, vector_valid;
    logic [7:0] isr, irr_clr, vector;

    pic_intr_ctrl dut (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr),
        .vec_base(vec_base), .aeoi(aeoi), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(int_out), .isr(isr), .irr_clr(irr_clr),
        .vector(vector), .vector_valid(vector_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irr, imr;
        logic [4:0] vb;
        logic [3:0] ctl;
        logic [2:0] el;
        logic       xint;
        logic [7:0] xisr, xclr, xvec;
        logic       xvv;
    } vec_t;

    // ctl = {aeoi, eoi, eoi_specific, inta}
    localparam logic [3:0] N  = 4'b0000;
    localparam logic [3:0] I  = 4'b0001;
    localparam logic [3:0] E  = 4'b0100;
    localparam logic [3:0] S  = 4'b0110;
    localparam logic [3:0] A  = 4'b1000;
    localparam logic [3:0] AI = 4'b1001;
    localparam logic [3:0] EI = 4'b0101;
    localparam logic [4:0] VB = 5'h10;
`ifdef ROTATE_EN
    localparam logic [7:0] RSEL = 8'h10;
    localparam logic [7:0] RVEC = 8'h84;
`else
    localparam logic [7:0] RSEL = 8'h08;
    localparam logic [7:0] RVEC = 8'h83;
`endif

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [7:0] i_irr, i_imr,
                                input logic [4:0] i_vb,
                                input logic [3:0] i_ctl,
                                input logic [2:0] i_el,
                                input logic x_int,
                                input logic [7:0] x_isr, x_clr, x_vec,
                                input logic x_vv);
        vec_t t;
        t.irr = i_irr; t.imr = i_imr; t.vb = i_vb; t.ctl = i_ctl;
        t.el = i_el; t.xint = x_int; t.xisr = x_isr; t.xclr = x_clr;
        t.xvec = x_vec; t.xvv = x_vv;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic xi,
                           input logic [7:0] xs, xc, xv, input logic xvv);
        chk({nm, ".int"}, idx, {7'd0, int_out}, {7'd0, xi});
        chk({nm, ".isr"}, idx, isr, xs);
        chk({nm, ".clr"}, idx, irr_clr, xc);
        chk({nm, ".vec"}, idx, vector, xv);
        chk({nm, ".vv"}, idx, {7'd0, vector_valid}, {7'd0, xvv});
    endtask

    task automatic apply(input string nm, input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        irr = v.irr; imr = v.imr; vec_base = v.vb; eoi_level = v.el;
        aeoi = v.ctl[3]; eoi = v.ctl[2];
        eoi_specific = v.ctl[1]; inta = v.ctl[0];
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(nm, idx, e.xint, e.xisr, e.xclr, e.xvec, e.xvv);
    endtask

    int hi = 0;
    task automatic step(input logic [7:0] i_irr, i_imr,
                        input logic [3:0] i_ctl, input logic [2:0] i_el,
                        input logic x_int, input logic [7:0] x_isr, x_clr,
                        input logic [7:0] x_vec, input logic x_vv);
        apply("seq", mk(i_irr, i_imr, VB, i_ctl, i_el,
                        x_int, x_isr, x_clr, x_vec, x_vv), hi);
        hi++;
    endtask

    initial begin
        tbl.push_back(mk(8'h04, 8'h00, VB, N,  3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mk(8'h04, 8'h00, VB, I,  3'd0, 1'b0, 8'h04, 8'h04, 8'h00, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h04, 8'h00, 8'h82, 1'b1));
        tbl.push_back(mk(8'h00, 8'h00, VB, N,  3'd0, 1'b0, 8'h04, 8'h00, 8'h82, 1'b0));
        tbl.push_back(mk(8'h08, 8'h00, VB, N,  3'd0, 1'b0, 8'h04, 8'h00, 8'h82, 1'b0));
        tbl.push_back(mk(8'h01, 8'h00, VB, N,  3'd0, 1'b1, 8'h04, 8'h00, 8'h82, 1'b0));
        tbl.push_back(mk(8'h01, 8'h00, VB, I,  3'd0, 1'b0, 8'h05, 8'h01, 8'h82, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h05, 8'h00, 8'h80, 1'b1));
        tbl.push_back(mk(8'h00, 8'h00, VB, E,  3'd0, 1'b0, 8'h04, 8'h00, 8'h80, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, S,  3'd2, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0));
        tbl.push_back(mk(8'h02, 8'h00, VB, N,  3'd0, 1'b1, 8'h00, 8'h00, 8'h80, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, N,  3'd0, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h00, 8'h00, 8'h87, 1'b1));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h00, 8'h00, 8'h87, 1'b0));
        tbl.push_back(mk(8'h10, 8'h00, VB, A,  3'd0, 1'b1, 8'h00, 8'h00, 8'h87, 1'b0));
        tbl.push_back(mk(8'h10, 8'h00, VB, AI, 3'd0, 1'b0, 8'h10, 8'h10, 8'h87, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, AI, 3'd0, 1'b0, 8'h00, 8'h00, 8'h84, 1'b1));
        tbl.push_back(mk(8'h04, 8'h00, VB, N,  3'd0, 1'b1, 8'h00, 8'h00, 8'h84, 1'b0));
        tbl.push_back(mk(8'h04, 8'h00, VB, I,  3'd0, 1'b0, 8'h04, 8'h04, 8'h84, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h04, 8'h00, 8'h82, 1'b1));
        tbl.push_back(mk(8'h02, 8'h00, VB, N,  3'd0, 1'b1, 8'h04, 8'h00, 8'h82, 1'b0));
        tbl.push_back(mk(8'h02, 8'h00, VB, I,  3'd0, 1'b0, 8'h06, 8'h02, 8'h82, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h06, 8'h00, 8'h81, 1'b1));
        tbl.push_back(mk(8'h00, 8'h00, VB, E,  3'd0, 1'b0, 8'h04, 8'h00, 8'h81, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, S,  3'd2, 1'b0, 8'h00, 8'h00, 8'h81, 1'b0));
        tbl.push_back(mk(8'h08, 8'h00, VB, N,  3'd0, 1'b1, 8'h00, 8'h00, 8'h81, 1'b0));
        tbl.push_back(mk(8'h08, 8'h00, VB, I,  3'd0, 1'b0, 8'h08, 8'h08, 8'h81, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, VB, I,  3'd0, 1'b0, 8'h08, 8'h00, 8'h83, 1'b1));
        tbl.push_back(mk(8'h04, 8'h00, VB, N,  3'd0, 1'b1, 8'h08, 8'h00, 8'h83, 1'b0));
        tbl.push_back(mk(8'h10, 8'h00, VB, N,  3'd0, 1'b0, 8'h08, 8'h00, 8'h83, 1'b0));
        tbl.push_back(mk(8'h10, 8'h00, VB, EI, 3'd0, 1'b0, 8'h10, 8'h10, 8'h83, 1'b0));
        tbl.push_back(mk(8'h00, 8'h00, 5'h05, I, 3'd0, 1'b0, 8'h10, 8'h00, 8'h2C, 1'b1));
        tbl.push_back(mk(8'h00, 8'h00, VB, E,  3'd0, 1'b0, 8'h00, 8'h00, 8'h2C, 1'b0));
        tbl.push_back(mk(8'h01, 8'h01, VB, N,  3'd0, 1'b0, 8'h00, 8'h00, 8'h2C, 1'b0));
        tbl.push_back(mk(8'h03, 8'h01, VB, N,  3'd0, 1'b1, 8'h00, 8'h00, 8'h2C, 1'b0));

        reset = 1'b1; irr = 8'd0; imr = 8'd0; vec_base = VB;
        aeoi = 1'b0; inta = 1'b0; eoi = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) apply("tbl", tbl[k], k);

        // Acknowledge in flight, then reset while in ACK1.
        step(8'h03, 8'h01, I, 3'd0, 1'b0, 8'h02, 8'h02, 8'h2C, 1'b0);
        @(negedge clk);
        reset = 1'b1; inta = 1'b1; irr = 8'd0; imr = 8'd0;
        @(posedge clk);
        #1;
        chk_all("rst_ack1", 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(8'h00, 8'h00, I, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Priority after a non-specific EOI of IR3.
        step(8'h08, 8'h00, N, 3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        step(8'h08, 8'h00, I, 3'd0, 1'b0, 8'h08, 8'h08, 8'h00, 1'b0);
        step(8'h00, 8'h00, I, 3'd0, 1'b0, 8'h08, 8'h00, 8'h83, 1'b1);
        step(8'h00, 8'h00, E, 3'd0, 1'b0, 8'h00, 8'h00, 8'h83, 1'b0);
        step(8'h18, 8'h00, N, 3'd0, 1'b1, 8'h00, 8'h00, 8'h83, 1'b0);
        step(8'h18, 8'h00, I, 3'd0, 1'b0, RSEL, RSEL, 8'h83, 1'b0);
        step(8'h00, 8'h00, I, 3'd0, 1'b0, RSEL, 8'h00, RVEC, 1'b1);

        @(negedge clk);
        inta = 1'b0; eoi = 1'b0; irr = 8'd0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
